// File: rtl/regfile32_bank_pkg.sv
// Shared constants and enable-vector helpers for the 32-entry register bank.
// Used by the top level and by both read ports.
package regfile32_bank_pkg;

    localparam int NREGS  = 32;
    localparam int ADDR_W = 5;
    localparam int WCNT_W = 16;

    typedef struct packed {
        logic is_zero;
        logic is_onehot;
        logic is_multihot;
    } onehot_t;

    // vec & (vec - 1) clears the lowest set bit, so any bit left over means two or more were set.
    function automatic onehot_t onehot_check(input logic [NREGS-1:0] vec);
        onehot_t res;
        res.is_zero     = (vec == '0);
        res.is_multihot = ((vec & (vec - NREGS'(1))) != '0);
        res.is_onehot   = !res.is_zero && !res.is_multihot;
        return res;
    endfunction

    // Only meaningful for a one-hot vector.
    function automatic logic [ADDR_W-1:0] onehot_to_idx(input logic [NREGS-1:0] vec);
        logic [ADDR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (vec[i]) begin
                idx = idx | ADDR_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: a 32:1 word mux with same-cycle write forwarding
// and an optional hardwired-zero register 0.
module regfile_read_port
    import regfile32_bank_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int ZERO_REG = 1,
    parameter int FWD      = 1
) (
    input  logic [NREGS*WIDTH-1:0] regs_flat,
    input  logic [ADDR_W-1:0]      rd_addr,
    input  logic                   fwd_valid,
    input  logic [ADDR_W-1:0]      fwd_idx,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data
);

    logic [WIDTH-1:0] words [NREGS];

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_word
            assign words[gi] = regs_flat[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // The zero-register check comes first so that it also wins over forwarding.
    always_comb begin
        rd_data = words[rd_addr];
        if (ZERO_REG != 0 && rd_addr == '0) begin
            rd_data = '0;
        end else if (FWD != 0 && fwd_valid && fwd_idx == rd_addr) begin
            rd_data = wr_data;
        end
    end

endmodule

// File: rtl/regfile32_bank.sv
// 32-entry register bank driven by a one-hot write-enable vector, with two
// forwarding read ports, a sticky multi-hot error flag and a saturating write counter.
module regfile32_bank
    import regfile32_bank_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int ZERO_REG = 1,
    parameter int FWD      = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREGS-1:0]    wr_en,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic [ADDR_W-1:0]   rd_addr_a,
    input  logic [ADDR_W-1:0]   rd_addr_b,
    output logic [WIDTH-1:0]    rd_data_a,
    output logic [WIDTH-1:0]    rd_data_b,
    output logic                onehot_err,
    output logic [WCNT_W-1:0]   wr_count
);

    onehot_t             chk;
    logic [ADDR_W-1:0]   wr_idx;
    logic                fwd_valid;
    logic [NREGS*WIDTH-1:0] regs_flat;
    logic                onehot_err_reg;
    logic [WCNT_W-1:0]   wr_count_reg;

    assign chk       = onehot_check(wr_en);
    assign wr_idx    = onehot_to_idx(wr_en);
    assign fwd_valid = chk.is_onehot && !rst;

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
            if (ZERO_REG != 0 && gi == 0) begin : g_zero
                assign regs_flat[gi*WIDTH +: WIDTH] = '0;
            end else begin : g_store
                logic [WIDTH-1:0] q_reg;
                // A multi-hot vector also has bit gi set, so gate with the one-hot check.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        q_reg <= '0;
                    end else if (wr_en[gi] && chk.is_onehot) begin
                        q_reg <= wr_data;
                    end
                end
                assign regs_flat[gi*WIDTH +: WIDTH] = q_reg;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            onehot_err_reg <= 1'b0;
        end else if (chk.is_multihot) begin
            onehot_err_reg <= 1'b1;
        end
    end

    // Writes to a discarded register 0 still count as accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count_reg <= '0;
        end else if (!chk.is_zero && !chk.is_multihot && wr_count_reg != '1) begin
            wr_count_reg <= wr_count_reg + WCNT_W'(1);
        end
    end

    assign onehot_err = onehot_err_reg;
    assign wr_count   = wr_count_reg;

    regfile_read_port #(
        .WIDTH    (WIDTH),
        .ZERO_REG (ZERO_REG),
        .FWD      (FWD)
    ) u_port_a (
        .regs_flat (regs_flat),
        .rd_addr   (rd_addr_a),
        .fwd_valid (fwd_valid),
        .fwd_idx   (wr_idx),
        .wr_data   (wr_data),
        .rd_data   (rd_data_a)
    );

    regfile_read_port #(
        .WIDTH    (WIDTH),
        .ZERO_REG (ZERO_REG),
        .FWD      (FWD)
    ) u_port_b (
        .regs_flat (regs_flat),
        .rd_addr   (rd_addr_b),
        .fwd_valid (fwd_valid),
        .fwd_idx   (wr_idx),
        .wr_data   (wr_data),
        .rd_data   (rd_data_b)
    );

endmodule
